byte_decode_stream: RTL
=======================

Name: byte_decode_stream

Overview:
- Parametrised Kyber ByteDecode_d engine. Unpacks one 256-coefficient polynomial from a little-endian byte stream of IW-bit words into NC coefficients per output beat.
- Supports d in {1,4,5,10,11,12} with valid/ready backpressure on both sides.
- For d=12, reduces mod q and flags out-of-range values, as required by the encapsulation-key check.
- Sits between the byte-stream loader and the NTT/polynomial RAM writer.

Parameters:
- IW, 64, input word width in bits; multiple of 8.
- NC, 4, coefficients per output beat; power of two, 1..16.
- CW, 12, output coefficient field width; fixed at 12.

Ports:
- i_clk, input, 1, clock.
- i_rstn, input, 1, asynchronous active-low reset.
- i_start, input, 1, single-cycle pulse; begins one polynomial.
- i_d, input, 4, bit width d; sampled on i_start.
- i_ibytes, input, IW, packed byte word; byte k occupies bits [8k+7:8k].
- i_ibytes_valid, input, 1, input word valid.
- o_ibytes_ready, output, 1, input word accepted when valid and ready are both high.
- o_coeffs, output, NC*CW, coefficient j of the beat at [j*CW +: CW].
- o_coeffs_valid, output, 1, output beat valid.
- i_coeffs_ready, input, 1, downstream accepts the beat.
- o_busy, output, 1, high from i_start acceptance until o_done.
- o_done, output, 1, one-cycle pulse after the last beat handshake.
- o_err, output, 1, sticky modulus-check failure for the current polynomial.

Behaviour:
- Reset (i_rstn low, asynchronous): all outputs 0, FSM to IDLE, buffer and counters cleared. Reset asserted mid-operation abandons the polynomial; nothing is resumed.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on i_start with legal i_d. i_start with illegal i_d is ignored: stays IDLE, no outputs change.
  - RUN -> DONE on the handshake of beat 256/NC.
  - DONE -> IDLE after one cycle; o_done=1 only in DONE.
  - i_start while not IDLE is ignored.
- Input side:
  - Exactly 4*d words per polynomial (256*d bits). A word counter stops acceptance after the last word.
  - o_ibytes_ready = RUN && words_left>0 && fill <= NC*12.
  - o_ibytes_ready is 0 in IDLE and DONE.
- Bit order:
  - Stream bit n = byte n/8, bit n%8 (LSB first).
  - Coefficient i, bit b = stream bit i*d+b.
- Bit buffer:
  - Width BW = IW + NC*12; fill count 0..BW.
  - An accepted word is appended above the current fill.
  - Extracting a beat removes NC*d bits from the LSB end (shift right).
  - Append and extract may occur in the same cycle: fill' = fill + IW - NC*d.
- Output register:
  - Loaded when fill >= NC*d and (!o_coeffs_valid || i_coeffs_ready).
  - Holds o_coeffs stable while valid && !ready.
  - Each coefficient is zero-extended from d bits.
- Latency: word accepted at edge t -> earliest o_coeffs_valid after edge t+1. Full throughput of one beat per cycle while the buffer holds at least NC*d bits.
- d=12 reduction:
  - A raw value x >= 3329 outputs x-3329 and sets o_err.
  - o_err is sticky through DONE and cleared on the next accepted i_start.
  - For d<12, no reduction is applied and o_err is never set.
- End of polynomial: total bits are a whole multiple of NC*d, so fill=0 at DONE. Any residual bits are a design error, guarded by an assertion.
- Beat counter: 0..256/NC-1; it wraps only via IDLE.

Decomposition:
- Package kyber_pkg:
  - KYBER_Q=3329, KYBER_N=256.
  - Legal-d check function.
  - words_per_poly(d)=256*d/IW.
  - Beats_per_poly = 256/NC.
- Sub-module decode_bitbuf:
  - Contains the shift buffer, fill counter, and append/extract logic, with NC*d-bit extract output.
  - The FSM, counters, reduction and output register stay in byte_decode_stream.

Test Plan:
1. d=1: 4 words of all ones, ready always high -> 64 beats, each {4{12'h001}}. o_done pulses one cycle after beat 64. Exactly 4 words accepted.
2. d=12: first word bytes 0x01,0x23,0x45 -> beat 0 coefficient 0 = 0x301, coefficient 1 = 0x452. Across 48 random words, all 64 beats match the golden model and o_err=0.
3. d=12: first 12 bits 0xFFF -> coefficient 0 = 0x2FE and o_err=1 through done. The next i_start clears o_err to 0.
4. d=11: i_coeffs_ready low for 10 cycles mid-stream -> o_coeffs unchanged while stalled. o_ibytes_ready drops once fill > 48. No loss or duplication; 44 words in, 64 beats out, all matching the model.
5. i_start with i_d=3 -> stays IDLE, o_busy=0. A subsequent i_start with d=5 runs normally: 20 words in, 64 beats out.
6. Assert i_rstn low after 20 words of a d=10 run -> all outputs 0 immediately. A new d=4 run then produces 16 words in and 64 correct beats.

Source files
------------

// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants, types and helpers for the Kyber ByteDecode
// stream path.
//   KYBER_Q / KYBER_N      : modulus and polynomial length
//   d_legal(d)             : 1 when d is a supported ByteDecode width
//   words_per_poly(d, iw)  : input words carrying one polynomial (256*d/iw)
//   beats_per_poly(nc)     : output beats per polynomial (256/nc)
//   lane_res_t             : one decoded coefficient plus its range flag
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;

  typedef struct packed {
    logic              bad;  // raw d=12 value was >= q before reduction
    logic [COEF_W-1:0] val;
  } lane_res_t;

  function automatic logic d_legal(input logic [3:0] d);
    return d inside {4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12};
  endfunction

  function automatic logic [15:0] words_per_poly(input logic [3:0] d, input int iw);
    return 16'((KYBER_N * int'(d)) / iw);
  endfunction

  function automatic int beats_per_poly(input int nc);
    return KYBER_N / nc;
  endfunction

endpackage

// File: rtl/decode_bitbuf.sv
// decode_bitbuf: LSB-first bit accumulator between the byte-word loader and
// the coefficient extractor.
//   i_clk, i_rstn : clock, async active-low reset
//   clr_i         : drop all buffered bits (start of a polynomial)
//   app_i/word_i  : append an IW-bit word above the current fill
//   ext_i, d_i    : remove NC*d bits from the LSB end this cycle
//   ext_o         : lowest NC*CW buffered bits (caller keeps NC*d of them)
//   fill_o        : number of valid bits held
//   avail_o       : at least NC*d bits are held
//   room_o        : a full word can be appended without overflow
import kyber_pkg::*;

module decode_bitbuf #(
  parameter  int IW = 64,
  parameter  int NC = 4,
  parameter  int CW = 12,
  localparam int BW = IW + NC*CW,
  localparam int FW = $clog2(BW+1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             clr_i,
  input  logic             app_i,
  input  logic [IW-1:0]    word_i,
  input  logic             ext_i,
  input  logic [3:0]       d_i,
  output logic [NC*CW-1:0] ext_o,
  output logic [FW-1:0]    fill_o,
  output logic             avail_o,
  output logic             room_o
);

  logic [BW-1:0] bits_q, bits_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [FW-1:0] ext_n, sh, fill_sh;

  assign ext_n   = FW'(NC) * FW'(d_i);
  assign sh      = ext_i ? ext_n : '0;
  // Fill after this cycle's extract; an appended word lands right above it,
  // so append and extract in one cycle need no ordering between them.
  assign fill_sh = fill_q - sh;

  always_comb begin
    bits_d = bits_q >> sh;
    fill_d = fill_sh;
    if (app_i) begin
      bits_d = bits_d | (BW'(word_i) << fill_sh);
      fill_d = fill_sh + FW'(IW);
    end
    if (clr_i) begin
      bits_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
    end
  end

  assign ext_o   = bits_q[NC*CW-1:0];
  assign fill_o  = fill_q;
  assign avail_o = (fill_q >= ext_n);
  // With fill <= NC*CW an appended word always fits in BW bits.
  assign room_o  = (fill_q <= FW'(NC*CW));

endmodule

// File: rtl/byte_decode_stream.sv
// byte_decode_stream: Kyber ByteDecode_d engine. Unpacks one 256-coefficient
// polynomial from a little-endian byte stream into NC coefficients per beat.
//   i_clk, i_rstn                  : clock, async active-low reset
//   i_start, i_d                   : begin a polynomial with width d
//   i_ibytes/_valid, o_ibytes_ready: packed input words (byte k at [8k+7:8k])
//   o_coeffs/_valid, i_coeffs_ready: output beats, lane j at [j*CW +: CW]
//   o_busy                         : polynomial in progress
//   o_done                         : one-cycle pulse after the last beat
//   o_err                          : sticky d=12 out-of-range flag
import kyber_pkg::*;

module byte_decode_stream #(
  parameter int IW = 64,
  parameter int NC = 4,
  parameter int CW = 12
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [3:0]       i_d,
  input  logic [IW-1:0]    i_ibytes,
  input  logic             i_ibytes_valid,
  output logic             o_ibytes_ready,
  output logic [NC*CW-1:0] o_coeffs,
  output logic             o_coeffs_valid,
  input  logic             i_coeffs_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int BW  = IW + NC*CW;
  localparam int FW  = $clog2(BW+1);
  localparam int NB  = beats_per_poly(NC);
  localparam int BTW = $clog2(NB);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       d_q, d_d;
  logic [15:0]      words_q, words_d;
  logic [BTW-1:0]   beat_q, beat_d;
  logic [NC*CW-1:0] coeffs_q, coeffs_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic             start_acc, app, load, hs;
  logic [NC*CW-1:0] ext_bits;
  logic [FW-1:0]    fill;
  logic             avail, room;
  logic [CW:0]      mask_w;
  logic [CW-1:0]    mask;

  lane_res_t [NC-1:0] lane;
  logic      [NC-1:0] lane_bad;
  logic [NC*CW-1:0]   lane_val;

  assign start_acc      = i_start && (state_q == ST_IDLE) && d_legal(i_d);
  assign o_ibytes_ready = (state_q == ST_RUN) && (words_q != '0) && room;
  assign app            = i_ibytes_valid && o_ibytes_ready;
  assign hs             = vld_q && i_coeffs_ready;
  assign load           = (state_q == ST_RUN) && avail && (!vld_q || i_coeffs_ready);

  decode_bitbuf #(.IW(IW), .NC(NC), .CW(CW)) u_bitbuf (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .clr_i   (start_acc),
    .app_i   (app),
    .word_i  (i_ibytes),
    .ext_i   (load),
    .d_i     (d_q),
    .ext_o   (ext_bits),
    .fill_o  (fill),
    .avail_o (avail),
    .room_o  (room)
  );

  // One extra bit so d=12 yields an all-ones mask instead of wrapping to 0.
  assign mask_w = ((CW+1)'(1) << d_q) - (CW+1)'(1);
  assign mask   = mask_w[CW-1:0];

  for (genvar j = 0; j < NC; j++) begin : g_lane
    logic [NC*CW-1:0] sh;
    logic [CW-1:0]    raw;
    logic             over;
    assign sh   = ext_bits >> (j * int'(d_q));
    assign raw  = sh[CW-1:0] & mask;
    // A 12-bit value is below 2q, so one conditional subtract reduces it.
    assign over = (d_q == 4'd12) && (raw >= CW'(KYBER_Q));
    assign lane[j].val = over ? (raw - CW'(KYBER_Q)) : raw;
    assign lane[j].bad = over;
    assign lane_bad[j] = lane[j].bad;
    assign lane_val[j*CW +: CW] = lane[j].val;
  end

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    words_d  = words_q;
    beat_d   = beat_q;
    coeffs_d = coeffs_q;
    err_d    = err_q;
    vld_d    = load ? 1'b1 : (hs ? 1'b0 : vld_q);
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_RUN;
          d_d     = i_d;
          words_d = words_per_poly(i_d, IW);
          beat_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (app) words_d = words_q - 16'd1;
        if (load) begin
          coeffs_d = lane_val;
          err_d    = err_q | (|lane_bad);
        end
        if (hs) begin
          if (beat_q == BTW'(NB-1)) begin
            state_d = ST_DONE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + BTW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      d_q      <= '0;
      words_q  <= '0;
      beat_q   <= '0;
      coeffs_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      words_q  <= words_d;
      beat_q   <= beat_d;
      coeffs_q <= coeffs_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign o_coeffs       = coeffs_q;
  assign o_coeffs_valid = vld_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_err          = err_q;

  // 256*d bits is a whole number of beats, so nothing may be left over.
  a_fill_empty_at_done: assert property (
    @(posedge i_clk) disable iff (!i_rstn) (state_q == ST_DONE) |-> (fill == '0));

endmodule
